seq_control_unit: RTL and testbench
===================================

Name: seq_control_unit

Overview:
- Fetch/execute sequencer for the 4-bit processor datapath.
- Drives the program counter, instruction/operand registers, accumulator, ALU select, I/O enables and the carry/zero flags register enable.
- Consumes the registered C/Z flags to resolve conditional jumps.
- Handles ROM ready wait-states with a timeout abort.

Parameters:
- MEM_WAIT_MAX, 15: consecutive not-ready cycles tolerated in FETCH/OPERAND before abort. Range 1..255; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clock clk
mem_ready  in  1  ROM data valid this cycle
instr_op  in  4  ROM data high nibble (opcode)
c_flag  in  1  registered carry from flags register
z_flag  in  1  registered zero from flags register
resume  in  1  leave HALT (sampled in HALT only)
fetch_req  out  1  ROM access request
ir_load  out  1  load instruction register
opr_load  out  1  load operand register (jump target)
pc_inc  out  1  PC increment
pc_load  out  1  PC load from operand register
acc_en  out  1  accumulator write enable
flags_en  out  1  flags register enable
alu_sel  out  3  000 passB, 001 add, 010 sub, 011 and, 100 or, 101 nand
in_sel  out  1  ALU B from input port instead of operand
out_en  out  1  output port latch enable
halted  out  1  state==HALT
bus_error  out  1  sticky timeout flag
state_dbg  out  3  IDLE=0, FETCH=1, OPERAND=2, EXEC=3, HALT=4

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, opcode reg=0, wait_cnt=0, bus_error=0.
  - All outputs 0 except state_dbg=0.
- Output timing: outputs are combinational from state, opcode reg and mem_ready; there are no registered outputs besides bus_error.
- IDLE: always goes to FETCH on the next clock.
- FETCH:
  - fetch_req=1.
  - If mem_ready=1: ir_load=1, pc_inc=1, opcode reg<=instr_op. Next state is OPERAND if instr_op in 0xA..0xE, else EXEC.
  - If mem_ready=0: stay in FETCH.
- OPERAND:
  - fetch_req=1.
  - If mem_ready=1: opr_load=1, pc_inc=1, next EXEC.
  - If mem_ready=0: stay in OPERAND.
- Wait timeout:
  - wait_cnt increments each FETCH/OPERAND cycle with mem_ready=0. It clears on mem_ready=1 and on any state change.
  - If MEM_WAIT_MAX>0, wait_cnt==MEM_WAIT_MAX and mem_ready=0: next state HALT, bus_error<=1.
  - Net effect: the (MEM_WAIT_MAX+1)th consecutive not-ready cycle aborts.
- EXEC: one cycle, decoded from the opcode reg, then next FETCH (except HLT).
  - 0x0 NOP: no enables.
  - 0x1 LIT: acc_en, alu_sel=000.
  - 0x2 ADDI: acc_en, flags_en, alu_sel=001.
  - 0x3 SUBI: acc_en, flags_en, alu_sel=010.
  - 0x4 ANDI: acc_en, flags_en, alu_sel=011.
  - 0x5 ORI: acc_en, flags_en, alu_sel=100.
  - 0x6 NANDI: acc_en, flags_en, alu_sel=101.
  - 0x7 CMPI: flags_en only, alu_sel=010.
  - 0x8 IN: acc_en, in_sel, alu_sel=000.
  - 0x9 OUT: out_en.
  - 0xA JMP: pc_load=1.
  - 0xB JC: pc_load=c_flag.
  - 0xC JNC: pc_load=~c_flag.
  - 0xD JZ: pc_load=z_flag.
  - 0xE JNZ: pc_load=~z_flag.
  - 0xF HLT: no enables; next HALT.
- Jump conditions: flags are sampled in the EXEC cycle. A not-taken jump has still consumed its operand byte (PC already past it).
- Flag hazard: a flags-writing instruction updates C/Z at the end of its EXEC cycle. The next instruction's EXEC is at least 2 cycles later, so it sees the new flags; no forwarding is needed.
- HALT:
  - All enables 0, halted=1.
  - resume=1 with bus_error=0 → next FETCH.
  - resume is ignored while bus_error=1; only reset clears bus_error.
- Minimum latency: non-jump 2 cycles/instruction; jump 3 cycles; +1 cycle per not-ready cycle.
- Mutual exclusion: pc_inc and pc_load are never both 1. alu_sel=000 whenever acc_en=0 and flags_en=0.

Test Plan:
- Reset release, mem_ready=1, ROM 0x0 (NOP) → state_dbg 0→1→3→1; ir_load/pc_inc pulse in FETCH; no enables in EXEC.
- ADDI then JC with c_flag=1 → ADDI EXEC: acc_en=1, flags_en=1, alu_sel=001. JC: opr_load in OPERAND, pc_load=1 in EXEC. Repeat with c_flag=0 → pc_load=0 and pc_inc seen twice.
- JNZ with z_flag=0 → pc_load=1; JZ with z_flag=0 → pc_load=0. CMPI EXEC → flags_en=1, acc_en=0.
- FETCH with mem_ready=0 for 3 cycles then 1 → fetch_req held 4 cycles, ir_load only on 4th; no bus_error.
- MEM_WAIT_MAX=15, mem_ready stuck 0 → after 16 not-ready cycles state=HALT, bus_error=1, halted=1. resume=1 has no effect.
- HLT executes → HALT; resume pulse → FETCH next clock. Assert reset mid-OPERAND → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/seq_control_unit.sv
// Fetch/execute sequencer for the 4-bit processor: walks FETCH/OPERAND/EXEC,
// decodes the opcode into datapath enables and aborts on stalled ROM reads.
module seq_control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic [3:0] instr_op,
  input  logic       c_flag,
  input  logic       z_flag,
  input  logic       resume,
  output logic       fetch_req,
  output logic       ir_load,
  output logic       opr_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_en,
  output logic       flags_en,
  output logic [2:0] alu_sel,
  output logic       in_sel,
  output logic       out_en,
  output logic       halted,
  output logic       bus_error,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_OPERAND = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_NAND  = 3'b101;

  localparam logic [7:0] WAIT_MAX   = 8'(MEM_WAIT_MAX);
  localparam bit         TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  state_t     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_error_q, bus_error_d;

  // Jumps (0xA..0xE) carry a target byte and need an OPERAND read.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    wait_cnt_d  = '0;
    bus_error_d = bus_error_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_OPERAND: begin
        if (mem_ready) begin
          if (state_q == S_FETCH) begin
            opcode_d = instr_op;
            state_d  = is_two_byte(instr_op) ? S_OPERAND : S_EXEC;
          end else begin
            state_d = S_EXEC;
          end
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_MAX)) begin
          state_d     = S_HALT;
          bus_error_d = 1'b1;
        end else begin
          // Saturate so a disabled timeout never wraps the counter.
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
      end
      S_EXEC: state_d = (opcode_q == 4'hF) ? S_HALT : S_FETCH;
      S_HALT: if (resume && !bus_error_q) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    opr_load  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_en    = 1'b0;
    flags_en  = 1'b0;
    alu_sel   = ALU_PASSB;
    in_sel    = 1'b0;
    out_en    = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_load   = mem_ready;
        pc_inc    = mem_ready;
      end
      S_OPERAND: begin
        fetch_req = 1'b1;
        opr_load  = mem_ready;
        pc_inc    = mem_ready;
      end
      S_EXEC: begin
        case (opcode_q)
          4'h1: acc_en = 1'b1;
          4'h2: begin acc_en = 1'b1; flags_en = 1'b1; alu_sel = ALU_ADD;  end
          4'h3: begin acc_en = 1'b1; flags_en = 1'b1; alu_sel = ALU_SUB;  end
          4'h4: begin acc_en = 1'b1; flags_en = 1'b1; alu_sel = ALU_AND;  end
          4'h5: begin acc_en = 1'b1; flags_en = 1'b1; alu_sel = ALU_OR;   end
          4'h6: begin acc_en = 1'b1; flags_en = 1'b1; alu_sel = ALU_NAND; end
          4'h7: begin flags_en = 1'b1; alu_sel = ALU_SUB; end
          4'h8: begin acc_en = 1'b1; in_sel = 1'b1; end
          4'h9: out_en = 1'b1;
          4'hA: pc_load = 1'b1;
          4'hB: pc_load = c_flag;
          4'hC: pc_load = ~c_flag;
          4'hD: pc_load = z_flag;
          4'hE: pc_load = ~z_flag;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign halted    = (state_q == S_HALT);
  assign bus_error = bus_error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: every output is packed into one
// vector and compared against hand-computed expectations each step.
module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [3:0] instr_op;
  logic       c_flag, z_flag, resume;
  logic       fetch_req, ir_load, opr_load, pc_inc, pc_load, acc_en, flags_en;
  logic [2:0] alu_sel;
  logic       in_sel, out_en, halted, bus_error;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  seq_control_unit #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .instr_op(instr_op),
    .c_flag(c_flag), .z_flag(z_flag), .resume(resume),
    .fetch_req(fetch_req), .ir_load(ir_load), .opr_load(opr_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_en(acc_en), .flags_en(flags_en),
    .alu_sel(alu_sel), .in_sel(in_sel), .out_en(out_en), .halted(halted),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {state, fetch_req, ir_load, opr_load, pc_inc, pc_load, acc_en, flags_en,
  //  alu_sel, in_sel, out_en, halted, bus_error}
  wire [16:0] obs = {state_dbg, fetch_req, ir_load, opr_load, pc_inc, pc_load,
                     acc_en, flags_en, alu_sel, in_sel, out_en, halted, bus_error};

  function automatic logic [16:0] ex(input int st, input bit fr, input bit ir,
                                     input bit opr, input bit pinc, input bit pld,
                                     input bit acc, input bit fl, input int alu,
                                     input bit ins, input bit oen, input bit hlt,
                                     input bit berr);
    return {3'(st), fr, ir, opr, pinc, pld, acc, fl, 3'(alu), ins, oen, hlt, berr};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input string tag, input logic [3:0] op);
    mem_ready = 1'b1;
    instr_op  = op;
    #1;
    chk(tag, obs, ex(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;
  endtask

  task automatic do_operand(input string tag);
    mem_ready = 1'b1;
    #1;
    chk(tag, obs, ex(2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;
  endtask

  task automatic do_exec(input string tag, input logic [16:0] e);
    #1;
    chk(tag, obs, e);
    cyc;
  endtask

  initial begin
    logic [16:0] e;
    reset = 1'b1; mem_ready = 1'b1; instr_op = 4'h0;
    c_flag = 1'b0; z_flag = 1'b0; resume = 1'b0;
    #2;
    chk("reset_state", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc; cyc;
    reset = 1'b0;
    #1;
    chk("idle", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;

    do_fetch("fetch_nop", 4'h0);
    do_exec("exec_nop", ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_fetch("fetch_addi", 4'h2);
    do_exec("exec_addi", ex(3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));

    c_flag = 1'b1;
    do_fetch("fetch_jc_t", 4'hB);
    do_operand("opr_jc_t");
    do_exec("exec_jc_taken", ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    c_flag = 1'b0;
    do_fetch("fetch_jc_nt", 4'hB);
    do_operand("opr_jc_nt");
    do_exec("exec_jc_not", ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    z_flag = 1'b0;
    do_fetch("fetch_jnz", 4'hE);
    do_operand("opr_jnz");
    do_exec("exec_jnz_taken", ex(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    do_fetch("fetch_jz", 4'hD);
    do_operand("opr_jz");
    do_exec("exec_jz_not", ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Single-byte opcodes 0x1..0x9 with their hand-decoded enables.
    for (int op = 1; op <= 9; op++) begin
      case (op)
        1: e = ex(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        2: e = ex(3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        3: e = ex(3, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0);
        4: e = ex(3, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0);
        5: e = ex(3, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
        6: e = ex(3, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        7: e = ex(3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        8: e = ex(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        default: e = ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      endcase
      do_fetch($sformatf("fetch_op%0h", op), 4'(op));
      do_exec($sformatf("exec_op%0h", op), e);
    end

    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("wait_%0d", i), obs, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc;
    end
    do_fetch("fetch_after_wait", 4'h0);
    do_exec("exec_after_wait", ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("stall_%0d", i), obs, ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc;
    end
    #1;
    chk("timeout_halt", obs, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    resume = 1'b1;
    cyc;
    resume = 1'b0;
    #1;
    chk("resume_ignored", obs, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    reset = 1'b1;
    #1;
    chk("reset_clears_err", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;
    reset = 1'b0;
    #1;
    chk("idle2", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;

    do_fetch("fetch_hlt", 4'hF);
    do_exec("exec_hlt", ex(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("halt", obs, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc;
    #1;
    chk("halt_hold", obs, ex(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    resume = 1'b1;
    cyc;
    resume = 1'b0;
    do_fetch("resume_fetch", 4'hA);

    mem_ready = 1'b0;
    #1;
    chk("operand_wait", obs, ex(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_mid", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
